i2s_tx: RTL and testbench

- Serializes the effect chain's output sample stream (data/vld, one sample per audio frame) onto an I2S link to the output codec/DAC.
- Sits at the tail of the pedal chain, after the last effect stage.
- Generates the bit clock and word select from the system clock and owns a one-entry holding buffer.
- Reports underrun and overrun of that buffer.
- Mono: each sample is sent on both left and right slots.

---
 rtl/sample_pkg.sv | 21 ++
 rtl/i2s_clk_gen.sv | 73 +++++++
 rtl/i2s_tx.sv | 118 +++++++++++
 tb/tb_i2s_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// -----------------------------------------------------------------------------
// sample_pkg
//   Shared types and defaults for the pedal-chain audio path.
//   - sample_t        : signed audio sample as it travels between effect stages
//   - I2S_* constants : default geometry of the I2S output link
//   - width_of()      : counter width helper that never returns zero
// -----------------------------------------------------------------------------
package sample_pkg;

    localparam int I2S_DATA_WIDTH = 8;
    localparam int I2S_SLOT_WIDTH = 32;
    localparam int I2S_SCLK_DIV   = 4;

    typedef logic signed [I2S_DATA_WIDTH-1:0] sample_t;

    // Bits needed to hold the values 0..n-1, at least one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// -----------------------------------------------------------------------------
// i2s_clk_gen
//   Bit clock / word select generator for the I2S transmitter.
//   Ports:
//     clk, rst     : system clock, asynchronous active-high reset
//     sclk         : I2S bit clock (registered)
//     lrclk        : I2S word select, 0 = left slot, 1 = right slot (registered)
//     fall_evt     : high on the clk cycle whose edge drives sclk 1->0
//     frame_start  : fall_evt that begins a new frame (bit counter wraps to 0)
//     slot_pos     : bit position within the slot that the fall edge starts
// -----------------------------------------------------------------------------
module i2s_clk_gen
    import sample_pkg::*;
#(
    parameter  int SLOT_WIDTH = I2S_SLOT_WIDTH,
    parameter  int SCLK_DIV   = I2S_SCLK_DIV,
    localparam int POS_W      = width_of(SLOT_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             sclk,
    output logic             lrclk,
    output logic             fall_evt,
    output logic             frame_start,
    output logic [POS_W-1:0] slot_pos
);

    localparam int DIV_W = width_of(SCLK_DIV);
    localparam int CNT_W = width_of(2 * SLOT_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [CNT_W-1:0] SLOT_N   = CNT_W'(SLOT_WIDTH);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_next;
    logic             div_tc;

    assign div_tc       = (div_cnt == DIV_LAST);
    assign fall_evt     = div_tc & sclk;
    assign bit_cnt_next = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
    assign frame_start  = fall_evt & (bit_cnt_next == '0);

    // Position inside the current slot; the right slot reuses 0..SLOT_WIDTH-1.
    assign slot_pos = (bit_cnt_next >= SLOT_N) ? POS_W'(bit_cnt_next - SLOT_N)
                                               : POS_W'(bit_cnt_next);

    // Reset parks the bit counter on the last bit of the right slot, so the
    // first fall event after reset wraps it to 0 and starts a fresh frame.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            bit_cnt <= CNT_LAST;
            lrclk   <= 1'b1;
        end else begin
            if (div_tc) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall_evt) begin
                bit_cnt <= bit_cnt_next;
                lrclk   <= (bit_cnt_next >= SLOT_N);
            end
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
//   Mono I2S transmitter at the tail of the effect chain. Each audio frame the
//   sample held in a one-entry buffer is loaded and sent MSB-first, with the
//   standard one-bit delay and zero padding, on both the left and right slots.
//   Ports:
//     clk, rst    : system clock, asynchronous active-high reset
//     data_i      : signed sample from the effect chain
//     vld_i       : single-cycle strobe qualifying data_i (no backpressure)
//     mute        : 1 = load zero samples instead of audio
//     sclk        : I2S bit clock, period 2*SCLK_DIV clk cycles
//     lrclk       : I2S word select, 0 = left slot, 1 = right slot
//     sdata       : I2S serial data, changes on sclk falling edges
//     frame_o     : one-cycle pulse when a frame sample is loaded
//     underrun_o  : one-cycle pulse, frame load found the buffer empty
//     overrun_o   : one-cycle pulse, vld_i replaced an unconsumed sample
// -----------------------------------------------------------------------------
module i2s_tx
    import sample_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH,
    parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
    parameter int SCLK_DIV   = I2S_SCLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  vld_i,
    input  logic                  mute,
    output logic                  sclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  frame_o,
    output logic                  underrun_o,
    output logic                  overrun_o
);

    localparam int POS_W = width_of(SLOT_WIDTH);

    generate
        if (SLOT_WIDTH < DATA_WIDTH + 1) begin : g_bad_slot
            $error("i2s_tx: SLOT_WIDTH must be at least DATA_WIDTH+1");
        end
        if (SCLK_DIV < 1) begin : g_bad_div
            $error("i2s_tx: SCLK_DIV must be at least 1");
        end
    endgenerate

    logic             fall_evt;
    logic             frame_start;
    logic [POS_W-1:0] slot_pos;

    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] frame_reg;
    logic [SLOT_WIDTH-1:0] slot_word;
    logic                  sdata_bit;

    i2s_clk_gen #(
        .SLOT_WIDTH (SLOT_WIDTH),
        .SCLK_DIV   (SCLK_DIV)
    ) u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .lrclk       (lrclk),
        .fall_evt    (fall_evt),
        .frame_start (frame_start),
        .slot_pos    (slot_pos)
    );

    // Slot image indexed by SLOT_WIDTH-1-p: bit p=0 is the I2S delay bit (0),
    // p=1..DATA_WIDTH carry the sample MSB-first, the rest is zero padding.
    assign slot_word = SLOT_WIDTH'(frame_reg) << (SLOT_WIDTH - 1 - DATA_WIDTH);
    assign sdata_bit = slot_word[POS_W'(SLOT_WIDTH - 1) - slot_pos];

    // sdata at a frame start is always the delay bit, so using the pre-load
    // frame_reg on that edge is harmless.
    // NOTE: the holding buffer is a single register, not a memory array, so it
    // is given a defined reset value along with the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdata      <= 1'b0;
            frame_o    <= 1'b0;
            underrun_o <= 1'b0;
            overrun_o  <= 1'b0;
            hold       <= '0;
            hold_full  <= 1'b0;
            frame_reg  <= '0;
        end else begin
            frame_o    <= frame_start;
            underrun_o <= frame_start & ~hold_full;
            // A write landing on the load cycle refills a buffer that is
            // being drained in the same edge, so it is not an overrun.
            overrun_o  <= vld_i & hold_full & ~frame_start;

            if (fall_evt) begin
                sdata <= sdata_bit;
            end

            if (frame_start) begin
                if (mute) begin
                    frame_reg <= '0;
                end else if (hold_full) begin
                    frame_reg <= hold;
                end
            end

            if (vld_i) begin
                hold      <= data_i;
                hold_full <= 1'b1;
            end else if (frame_start) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx
//   Directed bench for i2s_tx with DATA_WIDTH=8, SLOT_WIDTH=10, SCLK_DIV=2
//   (80-clk frame). Outputs are sampled on the falling clk edge.
// -----------------------------------------------------------------------------
module tb_i2s_tx;

    localparam int DW  = 8;
    localparam int SW  = 10;
    localparam int DIV = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_i;
    logic          vld_i;
    logic          mute;
    logic          sclk;
    logic          lrclk;
    logic          sdata;
    logic          frame_o;
    logic          underrun_o;
    logic          overrun_o;

    int n_checks = 0;
    int n_errors = 0;
    int ov_count = 0;

    always #5 clk = ~clk;

    i2s_tx #(
        .DATA_WIDTH (DW),
        .SLOT_WIDTH (SW),
        .SCLK_DIV   (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .vld_i      (vld_i),
        .mute       (mute),
        .sclk       (sclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .frame_o    (frame_o),
        .underrun_o (underrun_o),
        .overrun_o  (overrun_o)
    );

    always @(negedge clk) begin
        if (overrun_o === 1'b1) ov_count++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {sclk, lrclk, sdata, frame_o, underrun_o, overrun_o}
    function automatic logic [5:0] out_vec();
        return {sclk, lrclk, sdata, frame_o, underrun_o, overrun_o};
    endfunction

    task automatic wait_frame(input bit skip);
        int n = 0;
        if (skip) @(negedge clk);
        while (frame_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (frame_o !== 1'b1) check("frame_timeout", 32'(frame_o), 32'd1);
    endtask

    task automatic send(input logic [DW-1:0] d, output logic ov);
        data_i = d;
        vld_i  = 1'b1;
        @(negedge clk);
        ov     = overrun_o;
        vld_i  = 1'b0;
    endtask

    // Called on (or before) a frame-load negedge; captures the whole frame with
    // a receiver that samples sdata on sclk rise, ends on the next load negedge.
    task automatic capture_frame(input string tag, input logic [DW-1:0] exp_word,
                                 input logic exp_under);
        logic [SW-1:0] l_bits, r_bits, l_lr, r_lr, exp_bits;
        logic [DW-1:0] l_rx, r_rx;
        int            sclk_bad;
        l_bits = '0; r_bits = '0; l_lr = '0; r_lr = '0;
        l_rx = '0; r_rx = '0; sclk_bad = 0;
        wait_frame(1'b0);
        check({tag, "_underrun"}, 32'(underrun_o), 32'(exp_under));
        for (int p = 0; p < SW; p++)
            exp_bits[p] = (p >= 1 && p <= DW) ? exp_word[DW-p] : 1'b0;
        for (int k = 0; k < 2*SW; k++) begin
            for (int o = 0; o < 2*DIV; o++) begin
                if (sclk !== (o >= DIV)) sclk_bad++;
                if (o == DIV) begin
                    if (k < SW) begin
                        l_bits[k] = sdata;
                        l_lr[k]   = lrclk;
                    end else begin
                        r_bits[k-SW] = sdata;
                        r_lr[k-SW]   = lrclk;
                    end
                end
                @(negedge clk);
            end
        end
        for (int p = 1; p <= DW; p++) begin
            l_rx[DW-p] = l_bits[p];
            r_rx[DW-p] = r_bits[p];
        end
        check({tag, "_left_bits"},  32'(l_bits), 32'(exp_bits));
        check({tag, "_right_bits"}, 32'(r_bits), 32'(exp_bits));
        check({tag, "_left_lrclk"}, 32'(l_lr),   32'd0);
        check({tag, "_right_lrclk"},32'(r_lr),   32'((1 << SW) - 1));
        check({tag, "_left_rx"},    32'(l_rx),   32'(exp_word));
        check({tag, "_right_rx"},   32'(r_rx),   32'(exp_word));
        check({tag, "_sclk_shape"}, 32'(sclk_bad), 32'd0);
    endtask

    typedef struct {
        logic [5:0] exp;
    } rst_vec_t;

    typedef struct {
        string         name;
        bit            send;
        logic [DW-1:0] data;
        logic          mute;
        logic [DW-1:0] exp_word;
        logic          exp_under;
    } frm_vec_t;

    rst_vec_t rtab[8];
    frm_vec_t ftab[6];

    initial begin
        logic ov;
        int   ov0;

        // Outputs after clk edges 1..8 following reset release.
        rtab[0].exp = 6'b010000;
        rtab[1].exp = 6'b110000;
        rtab[2].exp = 6'b110000;
        rtab[3].exp = 6'b000110;
        rtab[4].exp = 6'b000000;
        rtab[5].exp = 6'b100000;
        rtab[6].exp = 6'b100000;
        rtab[7].exp = 6'b000000;

        ftab[0] = '{"basic_a5",   1'b1, 8'hA5, 1'b0, 8'hA5, 1'b0};
        ftab[1] = '{"neg_80",     1'b1, 8'h80, 1'b0, 8'h80, 1'b0};
        ftab[2] = '{"repeat_80",  1'b0, 8'h00, 1'b0, 8'h80, 1'b1};
        ftab[3] = '{"mute_7f",    1'b1, 8'h7F, 1'b1, 8'h00, 1'b0};
        ftab[4] = '{"after_mute", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
        ftab[5] = '{"basic_3c",   1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0};

        rst = 1'b1; vld_i = 1'b0; mute = 1'b0; data_i = '0;

        // Reset values and first frame timing
        repeat (2) @(negedge clk);
        check("in_reset", 32'(out_vec()), 32'b010000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_edge%0d", i + 1), 32'(out_vec()), 32'(rtab[i].exp));
        end

        // Table: each record drives the frame after the one it is applied in
        for (int i = 0; i < 6; i++) begin
            wait_frame(1'b0);
            ov0  = ov_count;
            mute = ftab[i].mute;
            if (ftab[i].send) begin
                send(ftab[i].data, ov);
                check({ftab[i].name, "_wr_ovr"}, 32'(ov), 32'd0);
            end
            wait_frame(1'b1);
            capture_frame(ftab[i].name, ftab[i].exp_word, ftab[i].exp_under);
            check({ftab[i].name, "_ovr_count"}, 32'(ov_count - ov0), 32'd0);
        end
        mute = 1'b0;

        // Overrun: two writes in one frame, newest wins
        wait_frame(1'b0);
        ov0 = ov_count;
        send(8'h11, ov);
        check("ovr_first_write", 32'(ov), 32'd0);
        repeat (5) @(negedge clk);
        send(8'h22, ov);
        check("ovr_second_write", 32'(ov), 32'd1);
        wait_frame(1'b1);
        capture_frame("ovr_frame", 8'h22, 1'b0);
        check("ovr_count", 32'(ov_count - ov0), 32'd1);

        // Reset mid-frame at bit_cnt=13 (right slot, p=3, sclk high)
        wait_frame(1'b0);
        repeat (55) @(negedge clk);
        check("pre_rst_state", 32'({sclk, lrclk, sdata}), 32'b111);
        #1 rst = 1'b1;
        #1 check("async_rst", 32'(out_vec()), 32'b010000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        capture_frame("post_midrst", 8'h00, 1'b1);

        // Write on the frame-load cycle: old hold goes out, new one stays held
        wait_frame(1'b0);
        ov0 = ov_count;
        send(8'h33, ov);
        check("simul_first_write", 32'(ov), 32'd0);
        repeat (78) @(negedge clk);
        data_i = 8'h44;
        vld_i  = 1'b1;
        @(negedge clk);
        check("simul_on_load", 32'({frame_o, overrun_o, underrun_o}), 32'b100);
        vld_i  = 1'b0;
        capture_frame("simul_33", 8'h33, 1'b0);
        capture_frame("simul_44", 8'h44, 1'b0);
        check("simul_ovr_count", 32'(ov_count - ov0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
